// File: rtl/float_pkg.sv
// Shared constants and types for the iterative bfloat16 divider.
package float_pkg;

  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 7;
  localparam int EXP_BIAS = 127;
  localparam int Q_BITS   = FRAC_W + 2;
  localparam int REM_W    = FRAC_W + 3;

  localparam logic [15:0]      QNAN    = 16'h7FC0;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // Flag positions within the big-endian flags vector [0:3]
  localparam int FLAG_INV = 0;
  localparam int FLAG_DZ  = 1;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/float_div_if.sv
// Operand and result handshakes of the bfloat16 divider.
interface float_div_if;
  logic        in_valid;
  logic        in_ready;
  logic [0:15] num1;
  logic [0:15] num2;
  logic        out_valid;
  logic        out_ready;
  logic [0:15] out;
  logic [0:3]  flags;

  modport master (
    output in_valid, num1, num2, out_ready,
    input  in_ready, out_valid, out, flags
  );

  modport slave (
    input  in_valid, num1, num2, out_ready,
    output in_ready, out_valid, out, flags
  );
endinterface

// File: rtl/mant_div_step.sv
// One restoring-division step: compare, optionally subtract, shift left.
module mant_div_step
  import float_pkg::*;
(
  input  logic [REM_W-1:0]  rem_i,
  input  logic [FRAC_W:0]   div_i,
  output logic              q_o,
  output logic [REM_W-1:0]  rem_o
);

  logic [REM_W-1:0] div_ext;
  logic [REM_W-1:0] diff;

  assign div_ext = {2'b00, div_i};
  assign q_o     = (rem_i >= div_ext);

  // Keep the difference when the divisor fits, otherwise the old remainder
  always_comb begin
    diff  = rem_i - div_ext;
    rem_o = (q_o ? diff : rem_i) << 1;
  end

endmodule

// File: rtl/float_div.sv
// Iterative bfloat16 divider: restoring mantissa division, one bit per cycle.
module float_div
  import float_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  float_div_if.slave  bus
);

  localparam logic [3:0] CNT_LAST = 4'(Q_BITS - 1);

  state_e             state_q, state_d;
  logic               s_q, s_d;
  logic [EXP_W-1:0]   e1_q, e1_d, e2_q, e2_d;
  logic [FRAC_W:0]    m2_q, m2_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [Q_BITS-1:0]  quo_q, quo_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [0:15]        out_q, out_d;
  logic [0:3]         flags_q, flags_d;
  logic               out_valid_q, out_valid_d;

  logic               step_q;
  logic [REM_W-1:0]   step_rem;

  logic signed [9:0]  e1_ext, e2_ext, exp_n;
  logic [FRAC_W-1:0]  frac_n;
  logic               zero1, zero2;
  logic [0:15]        res_out;
  logic [0:3]         res_flags;

  mant_div_step u_step (
    .rem_i (rem_q),
    .div_i (m2_q),
    .q_o   (step_q),
    .rem_o (step_rem)
  );

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.flags     = flags_q;

  // Normalise the quotient and resolve the special cases into a result word
  always_comb begin
    e1_ext = signed'({2'b00, e1_q});
    e2_ext = signed'({2'b00, e2_q});
    exp_n  = e1_ext - e2_ext + signed'(10'(EXP_BIAS))
             - (quo_q[Q_BITS-1] ? 10'sd0 : 10'sd1);
    frac_n = quo_q[Q_BITS-1] ? quo_q[Q_BITS-2:1] : quo_q[Q_BITS-3:0];
    zero1  = (e1_q == '0);
    zero2  = (e2_q == '0);
    res_flags = '0;
    res_out   = {s_q, exp_n[EXP_W-1:0], frac_n};
    if (e1_q == EXP_MAX || e2_q == EXP_MAX || (zero1 && zero2)) begin
      res_out = QNAN;
      res_flags[FLAG_INV] = 1'b1;
    end else if (zero2) begin
      res_out = {s_q, EXP_MAX, {FRAC_W{1'b0}}};
      res_flags[FLAG_DZ] = 1'b1;
    end else if (zero1) begin
      res_out = {s_q, {(EXP_W+FRAC_W){1'b0}}};
    end else if (exp_n >= 10'sd255) begin
      res_out = {s_q, EXP_MAX, {FRAC_W{1'b0}}};
      res_flags[FLAG_OVF] = 1'b1;
    end else if (exp_n <= 10'sd0) begin
      res_out = {s_q, {(EXP_W+FRAC_W){1'b0}}};
      res_flags[FLAG_UNF] = 1'b1;
    end
  end

  // Next-state and datapath updates for IDLE/CALC/NORM/DONE
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    e1_d        = e1_q;
    e2_d        = e2_q;
    m2_d        = m2_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          s_d     = bus.num1[0] ^ bus.num2[0];
          e1_d    = bus.num1[1:8];
          e2_d    = bus.num2[1:8];
          m2_d    = {1'b1, bus.num2[9:15]};
          rem_d   = {2'b00, 1'b1, bus.num1[9:15]};
          quo_d   = '0;
          cnt_d   = '0;
          flags_d = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[Q_BITS-2:0], step_q};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) state_d = NORM;
      end
      NORM: begin
        out_d       = res_out;
        flags_d     = res_flags;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= 1'b0;
      e1_q        <= '0;
      e2_q        <= '0;
      m2_q        <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      e1_q        <= e1_d;
      e2_q        <= e2_d;
      m2_q        <= m2_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: doc/float_div.md
Name: float_div

Overview:
- Iterative bfloat16 divider; the inverse operation of the team's combinational bfloat16 multiplier.
- Accepts one operand pair over a valid/ready handshake and runs restoring division of the mantissas, one quotient bit per cycle.
- Normalizes, applies the exponent and special-case rules, and presents the result over a second valid/ready handshake.
- Uses the same big-endian field layout as the multiplier: bit 0 sign, bits 1:8 biased exponent, bits 9:15 fraction.

Parameters:
- EXP_W, 8: exponent field width.
- FRAC_W, 7: fraction field width. Q_BITS = FRAC_W+2 is derived. Only the defaults are verified.
- EXP_BIAS, 127: exponent bias.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  high only in IDLE
- num1  input  [0:15]  dividend
- num2  input  [0:15]  divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out  output  [0:15]  quotient
- flags  output  [0:3]  bit0 inv, bit1 dz, bit2 ovf, bit3 unf

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset state: IDLE, out_valid=0, out=0, flags=0, in_ready=1. Reset asserted mid-operation aborts the operation; no output is produced for it.
- FSM states are IDLE, CALC, NORM, DONE.
- IDLE:
  - Accept when in_valid & in_ready. Register sign s = num1[0]^num2[0], both exponents, m1 = {1,frac1} and m2 = {1,frac2}.
  - Initialise remainder R = {0,0,m1} (FRAC_W+3 bits), count = 0, then go to CALC.
- CALC, one quotient bit per cycle, MSB first:
  - If R >= {0,0,m2}: q bit = 1, R = (R-m2)<<1.
  - Else: q bit = 0, R = R<<1.
  - After Q_BITS (9) cycles go to NORM.
  - Quotient q = b8.b7..b0, always in (0.5, 2). Result is truncated; no rounding.
- NORM (1 cycle), exponent computed in 10-bit signed arithmetic:
  - b8=1: frac = b7..b1, e = e1-e2+EXP_BIAS.
  - b8=0: frac = b6..b0, e = e1-e2+EXP_BIAS-1.
- Special cases, in priority order. The exponent-0 fraction is ignored (no denormals).
  1. Either exponent = 0xFF, or both operands zero (exponent 0): out = 0x7FC0, inv=1.
  2. num2 zero: out = {s,0xFF,0}, dz=1.
  3. num1 zero: out = {s,0,0}.
  4. e >= 255: out = {s,0xFF,0}, ovf=1.
  5. e <= 0: out = {s,0,0}, unf=1.
  6. Otherwise: out = {s,e[7:0],frac}.
- Latency is fixed for every case, special cases included (the counter still runs).
  - out_valid rises on the Q_BITS+1 (10th) rising edge after the accept edge.
  - Then go to DONE.
- DONE:
  - out and flags are held stable while out_valid=1 and out_ready=0. in_ready=0.
  - out_valid & out_ready: go to IDLE and clear out_valid; in_ready=1 next cycle.
  - No same-cycle accept in DONE.
  - Maximum throughput is one result per Q_BITS+3 cycles.
- in_valid or operand changes outside IDLE are ignored.
- flags are cleared on each accept.

Decomposition:
- Package float_pkg holds:
  - EXP_W, FRAC_W, EXP_BIAS.
  - QNAN = 16'h7FC0, EXP_MAX = 8'hFF.
  - flag bit indices.
  - FSM state enum.
- Sub-module mant_div_step: combinational single restoring step. Inputs R and divisor; outputs q bit and next R. Instantiated once in the CALC datapath.

Test Plan:
- 0x3F80 / 0x3F80 (1.0/1.0) -> out = 0x3F80, flags = 0, out_valid exactly 10 edges after accept; 0x3F80 / 0x4040 (1.0/3.0) -> 0x3EAA (b8=0 path, truncated).
- 0xC0C0 / 0x4000 (-6.0/2.0) -> 0xC040 (-3.0), sign = 1, b8=1 path.
- 0x3F80 / 0x0000 -> 0x7F80, dz; 0x0000 / 0x0000 -> 0x7FC0, inv; 0x0000 / 0x3F80 -> 0x0000, flags = 0; 0x7F80 / 0x3F80 -> 0x7FC0, inv.
- 0x7F00 / 0x3E80 -> e=256 -> 0x7F80, ovf; 0x0080 / 0x4000 -> e=0 -> 0x0000, unf; 0xFF00 / 0x3E80 -> 0xFF80, ovf.
- Hold out_ready=0 for 5 cycles after out_valid -> out and flags stable, in_ready = 0, a second in_valid is not accepted; release out_ready -> in_ready = 1 on the next cycle and the second pair is accepted.
- Pull rst_n low at CALC cycle 4 -> out_valid = 0, flags = 0, in_ready = 1 immediately; after release, 0x4000 / 0x4000 -> 0x3F80 with normal latency.
